bus_region_ctrl: RTL

- Parametrised successor to the fixed 8088 system-bus glue logic: ALE address latch, memory/IO chip-select decode and bus-cycle sequencing in one clocked block.
- Latches the multiplexed address and decodes it against NUM_REGIONS programmable base/mask/space windows.
- Drives one active-low chip select per region and inserts per-region programmable wait states by pulling READY low.
- Sits between the CPU bus pins and the memory/IO modules; replaces the hand-written latch and CS assigns at system top level.

---
 rtl/bus_region_pkg.sv | 27 ++
 rtl/bus_region_ctrl_if.sv | 28 ++
 rtl/region_match.sv | 13 +
 rtl/bus_region_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bus_region_pkg.sv
// Shared types and default region table for the bus region controller.
package bus_region_pkg;

    localparam int unsigned DEF_ADDR_W      = 20;
    localparam int unsigned DEF_NUM_REGIONS = 4;
    localparam int unsigned DEF_WS_W        = 3;

    typedef logic [DEF_ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        STROBE,
        WAIT,
        ACTIVE
    } state_e;

    // Index 0 is the rightmost element of each table.
    localparam addr_t [DEF_NUM_REGIONS-1:0] DEF_REGION_BASE =
        {20'h01C00, 20'h0FF00, 20'h00000, 20'h80000};
    localparam addr_t [DEF_NUM_REGIONS-1:0] DEF_REGION_MASK =
        {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000};
    localparam logic [DEF_NUM_REGIONS-1:0] DEF_REGION_IOM = 4'b1100;
    localparam logic [DEF_NUM_REGIONS-1:0][DEF_WS_W-1:0] DEF_REGION_WS =
        {3'd2, 3'd1, 3'd0, 3'd0};

endpackage

// File: rtl/bus_region_ctrl_if.sv
// CPU-side bus pins and controller outputs of the bus region controller.
interface bus_region_ctrl_if #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned NUM_REGIONS = 4
);
    logic                   ALE;
    logic [7:0]             AD;
    logic [ADDR_W-9:0]      A;
    logic                   IOM;
    logic                   RD;
    logic                   WR;
    logic [ADDR_W-1:0]      Address;
    logic [NUM_REGIONS-1:0] CS_N;
    logic                   READY;
    logic                   MISS;
    logic                   PROT_ERR;
    logic                   TIMEOUT_ERR;

    modport master (
        output ALE, AD, A, IOM, RD, WR,
        input  Address, CS_N, READY, MISS, PROT_ERR, TIMEOUT_ERR
    );

    modport slave (
        input  ALE, AD, A, IOM, RD, WR,
        output Address, CS_N, READY, MISS, PROT_ERR, TIMEOUT_ERR
    );
endinterface

// File: rtl/region_match.sv
// Combinational base/mask/space compare for one decoded region.
module region_match #(
    parameter int unsigned       ADDR_W = 20,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] MASK   = '0,
    parameter logic              IOM    = 1'b0
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              iom,
    output logic              hit
);
    assign hit = ((addr & MASK) == (BASE & MASK)) && (iom == IOM);
endmodule

// File: rtl/bus_region_ctrl.sv
// 8088-style address latch, region chip-select decode and wait-state sequencer.
// Optional strobe watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_region_ctrl
    import bus_region_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int unsigned WS_W        = DEF_WS_W,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter logic [NUM_REGIONS-1:0]             REGION_IOM  = DEF_REGION_IOM,
    parameter logic [NUM_REGIONS-1:0][WS_W-1:0]   REGION_WS   = DEF_REGION_WS,
    parameter int unsigned TIMEOUT     = 64
) (
    input logic              CLK,
    input logic              RESET,
    bus_region_ctrl_if.slave bus
);
    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   iom_q, iom_d;
    logic [NUM_REGIONS-1:0] cs_n_q, cs_n_d;
    logic                   ready_q, ready_d;
    logic                   miss_q, miss_d;
    logic                   prot_q, prot_d;
    logic [WS_W-1:0]        wcnt_q, wcnt_d;
    logic [NUM_REGIONS-1:0] hit, sel;
    logic [WS_W-1:0]        sel_ws;
    logic                   strobe;

    assign strobe = !bus.RD || !bus.WR;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_match
        region_match #(
            .ADDR_W (ADDR_W),
            .BASE   (REGION_BASE[i]),
            .MASK   (REGION_MASK[i]),
            .IOM    (REGION_IOM[i])
        ) u_match (
            .addr (addr_q),
            .iom  (iom_q),
            .hit  (hit[i])
        );
    end

    // Scan from the top so the lowest-indexed hit is the one left standing.
    always_comb begin
        sel    = '0;
        sel_ws = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
                sel_ws = REGION_WS[i];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           tout_q, tout_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        iom_d   = iom_q;
        cs_n_d  = cs_n_q;
        ready_d = ready_q;
        miss_d  = 1'b0;
        prot_d  = 1'b0;
        wcnt_d  = wcnt_q;
`ifdef BUS_TIMEOUT_EN
        wdog_d  = '0;
        tout_d  = 1'b0;
`endif
        if (bus.ALE) begin
            // ALE aborts whatever cycle is in flight.
            addr_d  = {bus.A, bus.AD};
            iom_d   = bus.IOM;
            cs_n_d  = '1;
            ready_d = 1'b1;
            state_d = DECODE;
        end else begin
            unique case (state_q)
                IDLE: ;
                DECODE: begin
                    cs_n_d  = ~sel;
                    wcnt_d  = sel_ws;
                    miss_d  = ~|hit;
                    state_d = STROBE;
                end
                STROBE: begin
                    if (strobe) begin
                        prot_d = !bus.RD && !bus.WR;
                        if (wcnt_q != '0) begin
                            ready_d = 1'b0;
                            state_d = WAIT;
                        end else begin
                            state_d = ACTIVE;
                        end
                    end
                end
                WAIT: begin
                    if (!strobe) begin
                        ready_d = 1'b1;
                        cs_n_d  = '1;
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                        if (wcnt_q == WS_W'(1)) begin
                            ready_d = 1'b1;
                            state_d = ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (!strobe) begin
                        cs_n_d  = '1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    cs_n_d  = '1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            endcase
`ifdef BUS_TIMEOUT_EN
            if (state_q == WAIT || state_q == ACTIVE) begin
                wdog_d = wdog_q + 1'b1;
                if (wdog_q == WdW'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    cs_n_d  = '1;
                    ready_d = 1'b1;
                    wdog_d  = '0;
                    state_d = IDLE;
                end
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            iom_q   <= 1'b0;
            cs_n_q  <= '1;
            ready_q <= 1'b1;
            miss_q  <= 1'b0;
            prot_q  <= 1'b0;
            wcnt_q  <= '0;
`ifdef BUS_TIMEOUT_EN
            wdog_q  <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            iom_q   <= iom_d;
            cs_n_q  <= cs_n_d;
            ready_q <= ready_d;
            miss_q  <= miss_d;
            prot_q  <= prot_d;
            wcnt_q  <= wcnt_d;
`ifdef BUS_TIMEOUT_EN
            wdog_q  <= wdog_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign bus.Address  = addr_q;
    assign bus.CS_N     = cs_n_q;
    assign bus.READY    = ready_q;
    assign bus.MISS     = miss_q;
    assign bus.PROT_ERR = prot_q;
`ifdef BUS_TIMEOUT_EN
    assign bus.TIMEOUT_ERR = tout_q;
`else
    assign bus.TIMEOUT_ERR = 1'b0;
`endif

endmodule
